// File: rtl/cpu_pkg.sv
// Shared CPU constants, branch FSM state type and offset sign-extension helper.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int OFFSET_W = 19;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } br_state_t;

    function automatic logic [DATA_W-1:0] sign_extend(input logic [OFFSET_W-1:0] off);
        return {{(DATA_W-OFFSET_W){off[OFFSET_W-1]}}, off};
    endfunction

endpackage

// File: rtl/pc_adder.sv
// Single PC adder shared by fetch increment (+1) and branch commit (+offset).
module pc_adder #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] incr,
    output logic [DATA_W-1:0] sum
);

    assign sum = pc + incr;

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with fetch/jump loads and a three-state conditional-branch resolver.
// Optional branch statistics counters are enabled with `define PC_BRANCH_STATS_EN.
//
// state  | meaning
// IDLE   | PC serves PCin/IncPC; br_req captures offset
// EVAL   | sample CON_Out into br_taken
// COMMIT | apply offset if taken, pulse br_done
module pc_branch_unit
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter int                OFFSET_W = cpu_pkg::OFFSET_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                IncPC,
    input  logic                PCin,
    input  logic [DATA_W-1:0]   Bus_Data,
    input  logic                br_req,
    input  logic [OFFSET_W-1:0] br_offset,
    input  logic                CON_Out,
`ifdef PC_BRANCH_STATS_EN
    output logic [15:0]         taken_cnt,
    output logic [15:0]         nottaken_cnt,
`endif
    output logic [DATA_W-1:0]   PC,
    output logic                br_busy,
    output logic                br_done,
    output logic                br_taken
);

    br_state_t          state, state_nx;
    logic [DATA_W-1:0]  pc_q, pc_nx;
    logic [DATA_W-1:0]  off_q, off_nx;
    logic               taken_q, taken_nx;
    logic [DATA_W-1:0]  incr, sum;
    logic [DATA_W-1:0]  off_sext;

    assign off_sext = {{(DATA_W-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};
    assign incr     = (state == COMMIT) ? off_q : DATA_W'(1);

    pc_adder #(.DATA_W(DATA_W)) u_pc_adder (
        .pc   (pc_q),
        .incr (incr),
        .sum  (sum)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            off_q   <= '0;
            taken_q <= 1'b0;
        end else begin
            state   <= state_nx;
            pc_q    <= pc_nx;
            off_q   <= off_nx;
            taken_q <= taken_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        off_nx   = off_q;
        taken_nx = taken_q;
        case (state)
            IDLE: begin
                // br_req outranks the fetch strobes issued in the same cycle
                if (br_req) begin
                    off_nx   = off_sext;
                    state_nx = EVAL;
                end else if (PCin) begin
                    pc_nx = Bus_Data;
                end else if (IncPC) begin
                    pc_nx = sum;
                end
            end
            EVAL: begin
                taken_nx = CON_Out;
                state_nx = COMMIT;
            end
            COMMIT: begin
                if (taken_q) pc_nx = sum;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign PC       = pc_q;
    assign br_busy  = (state != IDLE);
    assign br_done  = (state == COMMIT);
    assign br_taken = taken_q;

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else if (state == COMMIT) begin
            if (taken_q) begin
                if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
            end else begin
                if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; covers statistics counters when PC_BRANCH_STATS_EN is defined.
module tb_pc_branch_unit;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        IncPC;
    logic        PCin;
    logic [31:0] Bus_Data;
    logic        br_req;
    logic [18:0] br_offset;
    logic        CON_Out;
    logic [31:0] PC;
    logic        br_busy;
    logic        br_done;
    logic        br_taken;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    pc_branch_unit dut (
        .Clock        (Clock),
        .Clear        (Clear),
        .IncPC        (IncPC),
        .PCin         (PCin),
        .Bus_Data     (Bus_Data),
        .br_req       (br_req),
        .br_offset    (br_offset),
        .CON_Out      (CON_Out),
`ifdef PC_BRANCH_STATS_EN
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt),
`endif
        .PC           (PC),
        .br_busy      (br_busy),
        .br_done      (br_done),
        .br_taken     (br_taken)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_pc(input logic [31:0] v);
        PCin = 1'b1; Bus_Data = v;
        step();
        PCin = 1'b0; Bus_Data = '0;
        check("load_pc", PC, v);
    endtask

    task automatic do_branch(input string tag, input logic [31:0] start, input logic [18:0] off,
                             input logic con, input logic [31:0] exp_pc);
        load_pc(start);
        br_req = 1'b1; br_offset = off;
        step();
        br_req = 1'b0; br_offset = '0;
        check({tag, "_eval_busy"}, br_busy, 1);
        check({tag, "_eval_done"}, br_done, 0);
        CON_Out = con;
        step();
        CON_Out = ~con;
        check({tag, "_commit_done"}, br_done, 1);
        check({tag, "_commit_taken"}, br_taken, con);
        check({tag, "_commit_pc"}, PC, start);
        step();
        CON_Out = 1'b0;
        check({tag, "_pc"}, PC, exp_pc);
        check({tag, "_done_clr"}, br_done, 0);
        check({tag, "_busy_clr"}, br_busy, 0);
        check({tag, "_taken_hold"}, br_taken, con);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Clear = 1'b0; IncPC = 1'b0; PCin = 1'b0; Bus_Data = '0;
        br_req = 1'b0; br_offset = '0; CON_Out = 1'b0;
        repeat (2) step();
        check("rst_pc", PC, 32'h0);
        check("rst_busy", br_busy, 0);
        Clear = 1'b1;

        // async reset from a nonzero PC
        load_pc(32'h40);
        #2 Clear = 1'b0;
        #1;
        check("async_rst_pc", PC, 32'h0);
        check("async_rst_busy", br_busy, 0);
        check("async_rst_taken", br_taken, 0);
        step();
        Clear = 1'b1;

        IncPC = 1'b1;
        repeat (3) step();
        IncPC = 1'b0;
        check("fetch3", PC, 32'h3);
        IncPC = 1'b1; PCin = 1'b1; Bus_Data = 32'h100;
        step();
        IncPC = 1'b0; PCin = 1'b0; Bus_Data = '0;
        check("pcin_prio", PC, 32'h100);

        do_branch("taken", 32'h10, 19'h00005, 1'b1, 32'h15);
        do_branch("neg_nt", 32'h20, 19'h7FFFC, 1'b0, 32'h20);
        do_branch("neg_tk", 32'h20, 19'h7FFFC, 1'b1, 32'h1C);
        do_branch("min_off", 32'h0004_0000, 19'h40000, 1'b1, 32'h0);
        do_branch("pos_wrap", 32'hFFFF_FFFE, 19'h00003, 1'b1, 32'h1);

        // br_req with IncPC in IDLE, then strobes and br_req during EVAL
        load_pc(32'h30);
        br_req = 1'b1; br_offset = 19'h00002; IncPC = 1'b1;
        step();
        check("req_wins_pc", PC, 32'h30);
        br_req = 1'b1; IncPC = 1'b1; PCin = 1'b1; Bus_Data = 32'hDEAD; CON_Out = 1'b0;
        step();
        br_req = 1'b0; IncPC = 1'b1; PCin = 1'b1;
        check("lock_eval_pc", PC, 32'h30);
        check("lock_done", br_done, 1);
        step();
        IncPC = 1'b0; PCin = 1'b0; Bus_Data = '0;
        check("lock_commit_pc", PC, 32'h30);
        check("lock_idle", br_busy, 0);

        // abort in COMMIT
        load_pc(32'h50);
        br_req = 1'b1; br_offset = 19'h00004;
        step();
        br_req = 1'b0; CON_Out = 1'b1;
        step();
        CON_Out = 1'b0;
        check("abort_pre_done", br_done, 1);
        Clear = 1'b0;
        #1;
        check("abort_pc", PC, 32'h0);
        check("abort_done", br_done, 0);
        check("abort_busy", br_busy, 0);
        check("abort_taken", br_taken, 0);
        step();
        Clear = 1'b1;
        step();
        check("abort_after_pc", PC, 32'h0);
        check("abort_after_done", br_done, 0);

        load_pc(32'hFFFF_FFFF);
        IncPC = 1'b1;
        step();
        IncPC = 1'b0;
        check("inc_wrap", PC, 32'h0);

`ifdef PC_BRANCH_STATS_EN
        Clear = 1'b0;
        #1;
        check("stat_rst_t", taken_cnt, 0);
        check("stat_rst_n", nottaken_cnt, 0);
        step();
        Clear = 1'b1;
        do_branch("st1", 32'h100, 19'h00001, 1'b1, 32'h101);
        do_branch("st2", 32'h200, 19'h00002, 1'b0, 32'h200);
        do_branch("st3", 32'h300, 19'h7FFFF, 1'b1, 32'h2FF);
        check("stat_taken", taken_cnt, 2);
        check("stat_nottaken", nottaken_cnt, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage, directly downstream of the CON flip-flop.
- Holds the PC.
- On a conditional-branch request, the unit samples CON_Out, sign-extends the instruction C field and commits either PC+C (taken) or leaves PC unchanged (not taken).
- Also serves fetch increment (PC+1) and register-indirect jump loads (jr/jal) from the bus, under control-unit strobes.

Parameters:
- DATA_W, 32, PC/bus width
- OFFSET_W, 19, width of branch C field (sign-extended to DATA_W)
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- Clock  in  1  system clock, rising edge
- Clear  in  1  asynchronous, active-low reset
- IncPC  in  1  fetch strobe: PC <= PC+1
- PCin  in  1  load PC from Bus_Data (jr/jal)
- Bus_Data  in  DATA_W  shared bus
- br_req  in  1  one-cycle pulse: start conditional-branch resolution
- br_offset  in  OFFSET_W  C field of branch instruction, two's complement
- CON_Out  in  1  condition result from CON flip-flop
- PC  out  DATA_W  current program counter
- br_busy  out  1  high while FSM not IDLE
- br_done  out  1  one-cycle pulse when branch outcome committed
- br_taken  out  1  outcome of last resolved branch, held until next resolution

Behaviour:
- Reset (Clear=0, asynchronous): PC=RESET_PC, state=IDLE, br_busy=0, br_done=0, br_taken=0, captured offset=0. Reset mid-branch aborts without PC change.
- FSM states: IDLE, EVAL, COMMIT.
- IDLE:
  - br_req=1: capture sign-extended br_offset, go to EVAL.
  - Otherwise, PCin has priority over IncPC: PCin=1 gives PC<=Bus_Data; else IncPC=1 gives PC<=PC+1.
- EVAL (one cycle, lets CON_Out settle after CONin):
  - register br_taken<=CON_Out.
  - go to COMMIT.
- COMMIT:
  - if br_taken, PC<=PC+offset_sext (modulo 2^DATA_W, wrap-around silent); else PC held.
  - br_done=1 this cycle only.
  - return to IDLE.
- br_busy = (state != IDLE), combinational from state.
- Latency: br_req in cycle N; br_taken valid in N+2; PC update and br_done in N+2, visible on PC from N+3.
- While br_busy: IncPC, PCin and br_req are ignored (no queueing). The control unit must not issue them; if it does, PC is unaffected.
- br_req and PCin/IncPC in the same IDLE cycle: br_req wins and the other strobes are dropped.
- Offset arithmetic: offset_sext = {{(DATA_W-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset}. Negative offsets move PC backward.
- PC+1 at 32'hFFFF_FFFF wraps to 0.
- CON_Out is sampled only in EVAL; changes in other states are ignored.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined: adds outputs taken_cnt[15:0] and nottaken_cnt[15:0].
  - Incremented in COMMIT according to br_taken.
  - Saturate at 16'hFFFF.
  - Reset to 0 by Clear.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg: DATA_W and OFFSET_W constants, state enum br_state_t {IDLE, EVAL, COMMIT}, and a sign_extend function.
- One natural sub-module: pc_adder. It is a combinational DATA_W adder taking PC and a selected increment (1 or offset_sext), so one adder serves both fetch and branch.

Test Plan:
- Reset: Clear=0 with PC previously 32'h40 -> PC=0 immediately (async), br_busy=0, br_taken=0.
- Fetch: three IncPC cycles from 0 -> PC=3; IncPC+PCin with Bus_Data=32'h100 -> PC=32'h100.
- Taken branch: PC=32'h10, br_req, br_offset=19'h00005, CON_Out=1 in EVAL -> br_done at N+2, PC=32'h15, br_taken=1.
- Not-taken / negative offset: PC=32'h20, br_offset=19'h7FFFC (-4), CON_Out=0 -> PC stays 32'h20. Repeat with CON_Out=1 -> PC=32'h1C.
- Busy lockout and abort: during EVAL pulse IncPC and PCin -> PC unchanged. Second run: assert Clear in COMMIT -> PC=RESET_PC, state IDLE, no br_done.
- Wrap: PC=32'hFFFF_FFFF, IncPC -> PC=0. With PC_BRANCH_STATS_EN, 2 taken + 1 not-taken branches -> taken_cnt=2, nottaken_cnt=1.
